// File: rtl/lsu_pkg.sv
// Load/store unit shared types: data word, access-size and FSM state enums,
// plus the lane extract/merge helpers used by lsu_align.
package lsu_pkg;

  typedef logic [31:0] rvwordT;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } lsu_size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RDW,
    ST_WR,
    ST_RESP
  } lsu_state_e;

  // Pull the addressed byte/half out of a memory word and sign/zero extend it.
  // Word accesses return the word untouched, so the unsigned flag is ignored.
  function automatic rvwordT lsu_extract(rvwordT word, logic [1:0] off,
                                         lsu_size_e size, logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    rvwordT      r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Drop the low byte/half of wd into the addressed lane of old; other lanes keep
  // their previous contents.
  function automatic rvwordT lsu_merge(rvwordT old, rvwordT wd, logic [1:0] off,
                                       lsu_size_e size);
    rvwordT r;
    r = old;
    case (size)
      SZ_BYTE: r[{off, 3'b000} +: 8] = wd[7:0];
      SZ_HALF: begin
        if (off[1]) r[31:16] = wd[15:0];
        else        r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: load extraction/extension and, when the
// LSU_SUBWORD_EN macro is defined, the read-modify-write lane merge.
module lsu_align
  import lsu_pkg::*;
(
  input  rvwordT    i_rdata,
  input  logic [1:0] i_off,
  input  lsu_size_e i_size,
  input  logic      i_unsigned,
`ifdef LSU_SUBWORD_EN
  input  rvwordT    i_wdata,
  output rvwordT    o_merged,
`endif
  output rvwordT    o_load
);

  assign o_load = lsu_extract(i_rdata, i_off, i_size, i_unsigned);

`ifdef LSU_SUBWORD_EN
  assign o_merged = lsu_merge(i_rdata, i_wdata, i_off, i_size);
`endif

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core request at a time, drives a single-port
// word memory (read data one cycle after address) and returns a response.
// Byte/half accesses exist only when LSU_SUBWORD_EN is defined; otherwise any
// non-word size is reported as an error and the read-modify-write path is absent.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_store,
  input  logic [1:0] req_size,
  input  logic       req_unsigned,
  input  rvwordT     req_addr,
  input  rvwordT     req_wdata,
  output logic       resp_valid,
  input  logic       resp_ready,
  output rvwordT     resp_rdata,
  output logic       resp_err,
  output logic       dwe,
  output rvwordT     daddr,
  output rvwordT     ddatain,
  input  rvwordT     ddataout
);

  lsu_state_e r_state;
  logic       r_dwe;
  logic       r_resp_valid;
  logic       r_resp_err;
  rvwordT     r_resp_rdata;
  rvwordT     r_daddr;
  rvwordT     r_ddatain;

  logic [1:0] r_off;
  lsu_size_e  r_size;
  logic       r_uns;
`ifdef LSU_SUBWORD_EN
  logic       r_store;
  rvwordT     r_wdata;
  rvwordT     w_merged;
`endif

  lsu_size_e  w_size;
  rvwordT     w_word_addr;
  logic       w_oor;
  logic       w_misalign;
  logic       w_size_bad;
  logic       w_err;
  logic       w_accept;
  rvwordT     w_load;

  assign w_size      = lsu_size_e'(req_size);
  assign w_word_addr = {2'b00, req_addr[31:2]};
  assign w_oor       = (w_word_addr >> MEM_WIDTH) != '0;
`ifdef LSU_SUBWORD_EN
  assign w_size_bad  = (w_size == SZ_ILL);
`else
  assign w_size_bad  = (w_size != SZ_WORD);
`endif
  assign w_err       = w_size_bad | w_misalign | w_oor;

  // Ready is withheld while reset is held so nothing is accepted during reset.
  assign req_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;

  assign dwe        = r_dwe;
  assign daddr      = r_daddr;
  assign ddatain    = r_ddatain;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

  // Alignment check on the incoming request address.
  always_comb begin
    w_misalign = 1'b0;
    case (w_size)
      SZ_HALF: w_misalign = req_addr[0];
      SZ_WORD: w_misalign = |req_addr[1:0];
      default: w_misalign = 1'b0;
    endcase
  end

  // Capture the request attributes needed later in the transaction.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_off  <= req_addr[1:0];
      r_size <= w_size;
      r_uns  <= req_unsigned;
`ifdef LSU_SUBWORD_EN
      r_store <= req_store;
      r_wdata <= req_wdata;
`endif
    end
  end

  lsu_align u_align (
    .i_rdata    (ddataout),
    .i_off      (r_off),
    .i_size     (r_size),
    .i_unsigned (r_uns),
`ifdef LSU_SUBWORD_EN
    .i_wdata    (r_wdata),
    .o_merged   (w_merged),
`endif
    .o_load     (w_load)
  );

  // Transaction FSM with registered memory and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_dwe        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_daddr      <= '0;
      r_ddatain    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_daddr <= w_word_addr;
            if (w_err) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
              r_state      <= ST_RESP;
            end else if (req_store && (w_size == SZ_WORD)) begin
              r_dwe     <= 1'b1;
              r_ddatain <= req_wdata;
              r_state   <= ST_WR;
            end else begin
              r_state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          r_state <= ST_RDW;
        end
        ST_RDW: begin
`ifdef LSU_SUBWORD_EN
          if (r_store) begin
            r_ddatain <= w_merged;
            r_dwe     <= 1'b1;
            r_state   <= ST_WR;
          end else begin
            r_resp_rdata <= w_load;
            r_resp_err   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= ST_RESP;
          end
`else
          r_resp_rdata <= w_load;
          r_resp_err   <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
`endif
        end
        ST_WR: begin
          r_dwe        <= 1'b0;
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_dwe        <= 1'b0;
          r_resp_valid <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dwe;
  logic [31:0] daddr;
  logic [31:0] ddatain;
  logic [31:0] ddataout = '0;

  logic [31:0] mem [256];
  logic        tb_we = 1'b0;
  logic [7:0]  tb_wa = '0;
  logic [31:0] tb_wd = '0;
  int          wr_cnt = 0;

  int n_chk = 0;
  int n_err = 0;

  load_store_unit #(.MEM_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_store    (req_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .dwe          (dwe),
    .daddr        (daddr),
    .ddatain      (ddatain),
    .ddataout     (ddataout)
  );

  always #5 clk = ~clk;

  // Memory model: registered read, write on the edge where dwe is high.
  always @(posedge clk) begin
    if (tb_we) begin
      mem[tb_wa] <= tb_wd;
    end else if (dwe) begin
      mem[daddr[7:0]] <= ddatain;
      wr_cnt <= wr_cnt + 1;
    end
    ddataout <= mem[daddr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  // One full transaction; hold = cycles resp_ready stays low once resp_valid seen.
  task automatic xact(input logic st, input logic [1:0] sz, input logic un,
                      input logic [31:0] ad, input logic [31:0] wd, input int hold,
                      output int lat, output logic [31:0] rd, output logic er);
    int guard;
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
    req_addr = ad; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; guard = 0;
    while (!resp_valid && guard < 20) begin
      @(posedge clk); #1;
      lat++; guard++;
    end
    if (!resp_valid) chk("resp_timeout", 32'd0, 32'd1);
    rd = resp_rdata;
    er = resp_err;
    chk("req_ready_in_resp", {31'b0, req_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, resp_valid}, 32'd1);
      chk("hold_rdata", resp_rdata, rd);
      chk("hold_err", {31'b0, resp_err}, {31'b0, er});
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("resp_valid_clear", {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          w0;

    // Reset state while rst is held
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_dwe", {31'b0, dwe}, 32'd0);
    chk("rst_daddr", daddr, 32'd0);
    chk("rst_ddatain", ddatain, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

    poke(8'd0, 32'h80FF_0000);
    poke(8'd1, 32'h1122_3344);
    poke(8'd2, 32'h1234_5678);
    poke(8'd3, 32'h0000_0000);
    poke(8'd4, 32'hCAFE_F00D);

    // Word load
    xact(1'b0, 2'd2, 1'b0, 32'h0000_0008, 32'h0, 0, lat, rd, er);
    chk("ldw_data", rd, 32'h1234_5678);
    chk("ldw_err", {31'b0, er}, 32'd0);
    chk("ldw_lat", lat, 32'd3);

    // Word store, then read back with unsigned set (must be ignored)
    w0 = wr_cnt;
    xact(1'b1, 2'd2, 1'b1, 32'h0000_000C, 32'hA5A5_5A5A, 0, lat, rd, er);
    chk("stw_lat", lat, 32'd2);
    chk("stw_err", {31'b0, er}, 32'd0);
    chk("stw_rdata", rd, 32'd0);
    chk("stw_mem", mem[3], 32'hA5A5_5A5A);
    chk("stw_writes", wr_cnt - w0, 32'd1);
    xact(1'b0, 2'd2, 1'b1, 32'h0000_000C, 32'h0, 0, lat, rd, er);
    chk("ldw_back", rd, 32'hA5A5_5A5A);

    // Signed byte load of 0x80 at byte 3 of mem[0]
    xact(1'b0, 2'd0, 1'b0, 32'h0000_0003, 32'h0, 0, lat, rd, er);
`ifdef LSU_SUBWORD_EN
    chk("ldb_s_data", rd, 32'hFFFF_FF80);
    chk("ldb_s_err", {31'b0, er}, 32'd0);
    chk("ldb_s_lat", lat, 32'd3);
    xact(1'b0, 2'd0, 1'b1, 32'h0000_0002, 32'h0, 0, lat, rd, er);
    chk("ldb_u_data", rd, 32'h0000_00FF);
    xact(1'b0, 2'd1, 1'b0, 32'h0000_0002, 32'h0, 0, lat, rd, er);
    chk("ldh_s_data", rd, 32'hFFFF_80FF);
    xact(1'b0, 2'd1, 1'b1, 32'h0000_0002, 32'h0, 0, lat, rd, er);
    chk("ldh_u_data", rd, 32'h0000_80FF);
`else
    chk("ldb_s_err", {31'b0, er}, 32'd1);
    chk("ldb_s_data", rd, 32'd0);
    chk("ldb_s_lat", lat, 32'd1);
`endif

    // Half store 0xABCD at byte 6 (upper half of mem[1])
    w0 = wr_cnt;
    xact(1'b1, 2'd1, 1'b0, 32'h0000_0006, 32'h9999_ABCD, 0, lat, rd, er);
`ifdef LSU_SUBWORD_EN
    chk("sth_mem", mem[1], 32'hABCD_3344);
    chk("sth_writes", wr_cnt - w0, 32'd1);
    chk("sth_lat", lat, 32'd4);
    chk("sth_err", {31'b0, er}, 32'd0);
    chk("sth_rdata", rd, 32'd0);
    w0 = wr_cnt;
    xact(1'b1, 2'd0, 1'b0, 32'h0000_0005, 32'h1234_5677, 0, lat, rd, er);
    chk("stb_mem", mem[1], 32'hABCD_7744);
    chk("stb_writes", wr_cnt - w0, 32'd1);
`else
    chk("sth_err", {31'b0, er}, 32'd1);
    chk("sth_mem", mem[1], 32'h1122_3344);
    chk("sth_writes", wr_cnt - w0, 32'd0);
`endif

    // Misaligned word load
    w0 = wr_cnt;
    xact(1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'h0, 0, lat, rd, er);
    chk("mis_w_err", {31'b0, er}, 32'd1);
    chk("mis_w_rdata", rd, 32'd0);
    chk("mis_w_lat", lat, 32'd1);
    chk("mis_w_writes", wr_cnt - w0, 32'd0);

    // Misaligned half store
    w0 = wr_cnt;
    xact(1'b1, 2'd1, 1'b0, 32'h0000_0001, 32'h0000_FFFF, 0, lat, rd, er);
    chk("mis_h_err", {31'b0, er}, 32'd1);
    chk("mis_h_writes", wr_cnt - w0, 32'd0);

    // Illegal size
    xact(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0, 0, lat, rd, er);
    chk("ill_err", {31'b0, er}, 32'd1);
    chk("ill_lat", lat, 32'd1);

    // Out-of-range word store (index 0x10000 aliases mem[0] in the model)
    w0 = wr_cnt;
    xact(1'b1, 2'd2, 1'b0, 32'h0004_0000, 32'hDEAD_BEEF, 0, lat, rd, er);
    chk("oor_err", {31'b0, er}, 32'd1);
    chk("oor_rdata", rd, 32'd0);
    chk("oor_writes", wr_cnt - w0, 32'd0);
    chk("oor_mem0", mem[0], 32'h80FF_0000);

    // Highest in-range word loads normally
    xact(1'b0, 2'd2, 1'b0, 32'h0003_FFFC, 32'h0, 0, lat, rd, er);
    chk("top_err", {31'b0, er}, 32'd0);

    // Reset asserted during WR of a word store to 0x10
    w0 = wr_cnt;
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h0000_0010; req_wdata = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wr_dwe_high", {31'b0, dwe}, 32'd1);
    chk("wr_daddr", daddr, 32'd4);
    rst = 1'b1;
    #1;
    chk("wr_rst_dwe", {31'b0, dwe}, 32'd0);
    chk("wr_rst_req_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("wr_rst_mem4", mem[4], 32'hCAFE_F00D);
    chk("wr_rst_writes", wr_cnt - w0, 32'd0);
    chk("wr_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("wr_rst_ready_after", {31'b0, req_ready}, 32'd1);

    // Response held for 5 cycles with resp_ready low
    xact(1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'h0, 5, lat, rd, er);
    chk("hold_ld_data", rd, 32'h1122_3344 ^ (mem[1] ^ 32'h1122_3344));
    chk("hold_ld_lat", lat, 32'd3);

    // Back-to-back after a completed response still works
    xact(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 0, lat, rd, er);
    chk("b2b_data", rd, 32'hCAFE_F00D);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
